oc8051_pc_trace: RTL and testbench



---
 rtl/oc8051_pc_trace_pkg.sv | 13 +
 rtl/oc8051_pc_trace_if.sv | 34 +++
 rtl/oc8051_pc_trace_mem.sv | 23 ++
 rtl/oc8051_pc_trace.sv | 120 ++++++++++++
 tb/tb_oc8051_pc_trace.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oc8051_pc_trace_pkg.sv
// rtl/oc8051_pc_trace_pkg.sv - shared types and constants for the PC trace capture block
package oc8051_pc_trace_pkg;

    localparam int PC_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/oc8051_pc_trace_if.sv
// rtl/oc8051_pc_trace_if.sv - PC event stream, control and read port of the trace block
interface oc8051_pc_trace_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PC_W       = 16
);
    logic [PC_W-1:0]       pc_log_i;
    logic                  pc_log_change_i;
    logic                  assert_valid_i;
    logic                  arm_i;
    logic                  stop_i;
    logic                  trig_en_i;
    logic [PC_W-1:0]       trig_pc_i;
    logic [DEPTH_LOG2:0]   post_cnt_i;
    logic                  rd_ready_i;
    logic                  rd_valid_o;
    logic [PC_W-1:0]       rd_pc_o;
    logic                  rd_last_o;
    logic                  wrapped_o;
    logic [1:0]            state_o;

    // Producer/consumer side
    modport master (
        output pc_log_i, pc_log_change_i, assert_valid_i, arm_i, stop_i,
               trig_en_i, trig_pc_i, post_cnt_i, rd_ready_i,
        input  rd_valid_o, rd_pc_o, rd_last_o, wrapped_o, state_o
    );

    // Trace block side
    modport slave (
        input  pc_log_i, pc_log_change_i, assert_valid_i, arm_i, stop_i,
               trig_en_i, trig_pc_i, post_cnt_i, rd_ready_i,
        output rd_valid_o, rd_pc_o, rd_last_o, wrapped_o, state_o
    );
endinterface

// File: rtl/oc8051_pc_trace_mem.sv
// rtl/oc8051_pc_trace_mem.sv - 1-write/1-async-read register array, no reset
module oc8051_pc_trace_mem #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Store one entry per qualified write; contents survive reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/oc8051_pc_trace.sv
// rtl/oc8051_pc_trace.sv - PC trace capture: circular buffer, PC-match trigger, oldest-first drain
module oc8051_pc_trace
    import oc8051_pc_trace_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int PC_W       = PC_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    oc8051_pc_trace_if.slave     bus
);
    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] POST_MAX = (DEPTH_LOG2+1)'(DEPTH - 1);

    state_e                r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_post;
    logic [DEPTH_LOG2:0]   r_rd_cnt;
    logic                  r_wrapped;

    logic                  w_we;
    logic                  w_trig;
    logic [DEPTH_LOG2-1:0] w_post_ld;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
    logic                  w_wrapped_nxt;
    logic                  w_to_done;
    logic                  w_rd_valid;
    logic                  w_xfer;
    logic [PC_W-1:0]       w_rd_data;

    // Event qualification, trigger detection and the decision to close the window
    always_comb begin
        w_we          = bus.pc_log_change_i && bus.assert_valid_i
                        && (r_state == ARMED || r_state == POST);
        w_wr_ptr_nxt  = w_we ? r_wr_ptr + 1'b1 : r_wr_ptr;
        w_wrapped_nxt = r_wrapped | (w_we & (&r_wr_ptr));
        w_trig        = (r_state == ARMED) && w_we && bus.trig_en_i
                        && (bus.pc_log_i == bus.trig_pc_i);
        // Clamp keeps the trigger entry inside the buffer for the whole post window
        w_post_ld     = (bus.post_cnt_i > POST_MAX) ? POST_MAX[DEPTH_LOG2-1:0]
                                                    : bus.post_cnt_i[DEPTH_LOG2-1:0];
        w_to_done     = 1'b0;
        if (r_state == ARMED) begin
            w_to_done = bus.stop_i || (w_trig && (w_post_ld == '0));
        end else if (r_state == POST) begin
            w_to_done = bus.stop_i || (w_we && (r_post == DEPTH_LOG2'(1)));
        end
        w_rd_valid    = (r_state == DONE) && (r_rd_cnt != '0);
        w_xfer        = w_rd_valid && bus.rd_ready_i;
    end

    // Capture/drain FSM with write pointer, post counter and read window bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_cnt  <= '0;
            r_post    <= '0;
            r_wrapped <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.arm_i) begin
                        r_wr_ptr  <= '0;
                        r_wrapped <= 1'b0;
                        r_state   <= ARMED;
                    end
                end
                ARMED, POST: begin
                    r_wr_ptr  <= w_wr_ptr_nxt;
                    r_wrapped <= w_wrapped_nxt;
                    if (w_trig) begin
                        r_post <= w_post_ld;
                    end else if (r_state == POST && w_we) begin
                        r_post <= r_post - 1'b1;
                    end
                    if (w_to_done) begin
                        // Window bounds use the post-write pointer so a same-cycle event is included
                        r_rd_ptr <= w_wrapped_nxt ? w_wr_ptr_nxt : '0;
                        r_rd_cnt <= w_wrapped_nxt ? CNT_FULL : {1'b0, w_wr_ptr_nxt};
                        r_state  <= DONE;
                    end else if (w_trig) begin
                        r_state <= POST;
                    end
                end
                DONE: begin
                    if (w_xfer) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_rd_cnt <= r_rd_cnt - 1'b1;
                    end
                    if (r_rd_cnt == '0 || (w_xfer && r_rd_cnt == (DEPTH_LOG2+1)'(1))) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    oc8051_pc_trace_mem #(
        .AW (DEPTH_LOG2),
        .DW (PC_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.pc_log_i),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign bus.rd_valid_o = w_rd_valid;
    assign bus.rd_pc_o    = w_rd_valid ? w_rd_data : '0;
    assign bus.rd_last_o  = w_rd_valid && (r_rd_cnt == (DEPTH_LOG2+1)'(1));
    assign bus.wrapped_o  = r_wrapped;
    assign bus.state_o    = r_state;
endmodule

// File: tb/tb_oc8051_pc_trace.sv
// tb/tb_oc8051_pc_trace.sv - directed and randomized bench with a queue-based capture model
module tb_oc8051_pc_trace;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    oc8051_pc_trace_if #(.DEPTH_LOG2(DL), .PC_W(16)) bus ();

    oc8051_pc_trace #(.DEPTH_LOG2(DL), .PC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 armed, 2 post, 3 done; hist holds every stored PC since arm
    int          m_phase = 0;
    int          m_post  = 0;
    logic        m_wrapped = 1'b0;
    logic [15:0] m_hist[$];
    logic [15:0] m_win[$];
    logic [15:0] got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic evt;
        logic go_done;
        int   n;
        int   p;
        evt = bus.pc_log_change_i & bus.assert_valid_i;
        if (rst) begin
            m_phase = 0; m_wrapped = 1'b0; m_win.delete(); m_hist.delete();
            return;
        end
        case (m_phase)
            0: if (bus.arm_i) begin
                   m_hist.delete(); m_wrapped = 1'b0; m_phase = 1;
               end
            1, 2: begin
                go_done = 1'b0;
                if (evt) begin
                    m_hist.push_back(bus.pc_log_i);
                    if (m_hist.size() >= DEPTH) m_wrapped = 1'b1;
                    if (m_phase == 1) begin
                        if (bus.trig_en_i && bus.pc_log_i == bus.trig_pc_i) begin
                            p = (int'(bus.post_cnt_i) < DEPTH - 1) ? int'(bus.post_cnt_i) : DEPTH - 1;
                            if (p == 0) go_done = 1'b1;
                            else begin m_phase = 2; m_post = p; end
                        end
                    end else begin
                        m_post--;
                        if (m_post == 0) go_done = 1'b1;
                    end
                end
                if (bus.stop_i) go_done = 1'b1;
                if (go_done) begin
                    m_phase = 3;
                    n = (m_hist.size() < DEPTH) ? m_hist.size() : DEPTH;
                    m_win.delete();
                    for (int i = m_hist.size() - n; i < m_hist.size(); i++) m_win.push_back(m_hist[i]);
                end
            end
            default: begin
                if (m_win.size() == 0) m_phase = 0;
                else if (bus.rd_ready_i) begin
                    void'(m_win.pop_front());
                    if (m_win.size() == 0) m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic compare();
        logic mv;
        mv = (m_phase == 3) && (m_win.size() != 0);
        chk("state", bus.state_o, m_phase);
        chk("wrapped", bus.wrapped_o, m_wrapped);
        chk("rd_valid", bus.rd_valid_o, mv);
        if (mv) begin
            chk("rd_pc", bus.rd_pc_o, m_win[0]);
            chk("rd_last", bus.rd_last_o, m_win.size() == 1);
        end
    endtask

    task automatic cyc();
        if (bus.rd_valid_o && bus.rd_ready_i) got.push_back(bus.rd_pc_o);
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic quiet();
        bus.pc_log_change_i = 0; bus.assert_valid_i = 0;
        bus.arm_i = 0; bus.stop_i = 0;
    endtask

    task automatic ev(input logic [15:0] pc, input logic chg, input logic av);
        bus.pc_log_i = pc; bus.pc_log_change_i = chg; bus.assert_valid_i = av;
        cyc();
        quiet();
    endtask

    task automatic arm();
        got.delete();
        bus.arm_i = 1; cyc(); bus.arm_i = 0;
    endtask

    task automatic stop();
        bus.stop_i = 1; cyc(); bus.stop_i = 0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random with random noise on other inputs
    task automatic drain(input int mode);
        for (int n = 0; n < 200 && m_phase != 0; n++) begin
            case (mode)
                0: bus.rd_ready_i = 1;
                1: bus.rd_ready_i = n[0];
                default: begin
                    bus.rd_ready_i      = $urandom_range(1, 0);
                    bus.arm_i           = $urandom_range(1, 0);
                    bus.stop_i          = $urandom_range(1, 0);
                    bus.pc_log_change_i = $urandom_range(1, 0);
                    bus.assert_valid_i  = 1;
                    bus.pc_log_i        = 16'($urandom);
                end
            endcase
            cyc();
        end
        quiet();
        bus.rd_ready_i = 0;
        chk("drain_idle", bus.state_o, 0);
    endtask

    initial begin
        logic [15:0] e1[5];
        logic        saw77;
        quiet();
        bus.pc_log_i = 0; bus.trig_en_i = 0; bus.trig_pc_i = 0;
        bus.post_cnt_i = 0; bus.rd_ready_i = 0;
        rst = 1; cyc(); cyc(); rst = 0;
        chk("reset_rd_pc", bus.rd_pc_o, 0);
        chk("reset_rd_last", bus.rd_last_o, 0);

        // Trigger window
        bus.trig_en_i = 1; bus.trig_pc_i = 16'h0040; bus.post_cnt_i = 2;
        arm();
        ev(16'h0010, 1, 1); ev(16'h0020, 1, 1); ev(16'h0040, 1, 1);
        chk("t1_post", bus.state_o, 2);
        ev(16'h0041, 1, 1); ev(16'h0043, 1, 1);
        chk("t1_done", bus.state_o, 3);
        chk("t1_first", bus.rd_pc_o, 16'h0010);
        drain(0);
        e1 = '{16'h0010, 16'h0020, 16'h0040, 16'h0041, 16'h0043};
        chk("t1_len", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("t1_rd%0d", i), got[i], e1[i]);

        // Wrap and stop
        bus.trig_en_i = 0;
        arm();
        for (int i = 0; i < 20; i++) ev(16'(i), 1, 1);
        stop();
        chk("t2_wrapped", bus.wrapped_o, 1);
        drain(0);
        chk("t2_len", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk($sformatf("t2_rd%0d", i), got[i], 16'(i + 4));

        // Post clamp
        bus.trig_en_i = 1; bus.trig_pc_i = 16'h0100; bus.post_cnt_i = 31;
        arm();
        for (int i = 0; i < 5; i++) ev(16'h0200 + 16'(i), 1, 1);
        ev(16'h0100, 1, 1);
        for (int i = 0; i < 20; i++) ev(16'h0300 + 16'(i), 1, 1);
        drain(0);
        chk("t3_len", got.size(), 16);
        if (got.size() > 0) chk("t3_first", got[0], 16'h0100);

        // Qualification and backpressure
        bus.trig_en_i = 0;
        arm();
        ev(16'h0011, 1, 1); ev(16'h0077, 1, 0); ev(16'h0078, 0, 1);
        ev(16'h0012, 1, 1); ev(16'h0013, 1, 1);
        stop();
        drain(1);
        chk("t4_len", got.size(), 3);
        saw77 = 0;
        foreach (got[i]) if (got[i] == 16'h0077 || got[i] == 16'h0078) saw77 = 1;
        chk("t4_unqualified", saw77, 0);

        // Empty stop
        arm();
        stop();
        chk("t5_state", bus.state_o, 3);
        chk("t5_valid", bus.rd_valid_o, 0);
        cyc();
        chk("t5_idle", bus.state_o, 0);

        // Reset in POST
        arm();
        for (int i = 0; i < 18; i++) ev(16'h0500 + 16'(i), 1, 1);
        bus.trig_en_i = 1; bus.trig_pc_i = 16'h0600; bus.post_cnt_i = 5;
        ev(16'h0600, 1, 1); ev(16'h0601, 1, 1); ev(16'h0602, 1, 1);
        chk("t6_post", bus.state_o, 2);
        rst = 1; cyc(); rst = 0;
        chk("t6_state", bus.state_o, 0);
        chk("t6_valid", bus.rd_valid_o, 0);
        chk("t6_wrapped", bus.wrapped_o, 0);
        arm();
        ev(16'h0700, 1, 1); ev(16'h0600, 1, 1);
        for (int i = 0; i < 5; i++) ev(16'h0800 + 16'(i), 1, 1);
        drain(0);
        chk("t6_len", got.size(), 7);

        // Randomized capture rounds checked cycle by cycle against the model
        for (int r = 0; r < 12; r++) begin
            bus.trig_en_i  = $urandom_range(1, 0);
            bus.trig_pc_i  = 16'($urandom_range(63, 0));
            bus.post_cnt_i = 5'($urandom_range(31, 0));
            for (int k = 0; k < 3; k++) ev(16'($urandom_range(63, 0)), 1, 1);
            arm();
            for (int n = 0; n < 80 && (m_phase == 1 || m_phase == 2); n++) begin
                bus.pc_log_i        = 16'($urandom_range(63, 0));
                bus.pc_log_change_i = ($urandom_range(3, 0) != 0);
                bus.assert_valid_i  = ($urandom_range(7, 0) != 0);
                bus.stop_i          = ($urandom_range(63, 0) == 0);
                bus.arm_i           = $urandom_range(1, 0);
                cyc();
            end
            quiet();
            if (m_phase == 1 || m_phase == 2) stop();
            drain(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
